// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the E-stage divide sequencer.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage : div_sequencer_pkg

// File: rtl/div_datapath.sv
// Radix-2 restoring divide datapath: operand magnitudes, the remainder/quotient
// shift pair, one compare/subtract per step, and the final sign fix-up.
import div_sequencer_pkg::*;

module div_datapath #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 finish_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               negq_q;
    logic               negr_q;
    logic [2*WIDTH-1:0] result_q;

    logic               opa_neg;
    logic               opb_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    // Operand magnitudes and one restoring step on {rem, quo}.
    always_comb begin
        opa_neg = signed_i & opa_i[WIDTH-1];
        opb_neg = signed_i & opb_i[WIDTH-1];
        abs_a   = opa_neg ? -opa_i : opa_i;
        abs_b   = opb_neg ? -opb_i : opb_i;
        // The extra top bit keeps the shifted-out remainder bit, so the
        // compare stays correct for divisors with their MSB set.
        partial = {rem_q, quo_q[WIDTH-1]};
        trial   = partial - {1'b0, div_q};
        ge      = (partial >= {1'b0, div_q});
        rem_d   = ge ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
        rem_fix = negr_q ? -rem_d : rem_d;
        quo_fix = negq_q ? -quo_d : quo_d;
    end

    // Operand latch on load, shift/subtract on step, result capture on finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else if (load_i) begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            if (opb_i == '0) begin
                result_q <= {opa_i, {WIDTH{1'b1}}};
            end else begin
                rem_q  <= '0;
                quo_q  <= abs_a;
                div_q  <= abs_b;
                negq_q <= opa_neg ^ opb_neg;
                negr_q <= opa_neg;
            end
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (finish_i) begin
                result_q <= {rem_fix, quo_fix};
            end
        end
    end

    assign result_o = result_q;

endmodule : div_datapath

// File: rtl/div_sequencer.sv
// E-stage divide sequencer: IDLE/BUSY/DONE control, iteration counter and the
// pipeline stall/ready handshake around div_datapath.
import div_sequencer_pkg::*;

module div_sequencer #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic                 annul_i,
    input  logic                 ehold_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 load;
    logic                 step;
    logic                 finish;

    // State and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath controls and stall/ready; annul_i overrides all.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        stall_o = 1'b0;
        ready_o = 1'b0;
        if (annul_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        stall_o = 1'b1;
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = (opb_i == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    stall_o = 1'b1;
                    step    = 1'b1;
                    if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                        finish  = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Wait out an external hold so a still-present start_i
                    // is not taken as a fresh instruction.
                    ready_o = 1'b1;
                    if (!ehold_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    div_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .finish_i (finish),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .result_o (result_o)
    );

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: timing, sign cases, divide by zero,
// annul, external hold in DONE and asynchronous reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic        ehold_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int total = 0;
    int bad   = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .annul_i  (annul_i),
        .ehold_i  (ehold_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start_i  = 1'b1;
        signed_i = sgn;
        opa_i    = a;
        opb_i    = b;
    endtask

    // Count stalled cycles from the issue cycle (cycle 0) until ready_o.
    task automatic run(output int n_stall, output int n_ready);
        n_stall = 0;
        n_ready = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall_o) n_stall++;
            if (ready_o) begin
                n_ready = i;
                break;
            end
            tick();
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_cyc);
        int ns, nr;
        issue(sgn, a, b);
        run(ns, nr);
        chk({tag, "_stall_cycles"}, ns, exp_cyc);
        chk({tag, "_ready_cycle"}, nr, exp_cyc);
        chk({tag, "_result"}, result_o, exp_res);
        tick();
        start_i = 1'b0;
        #1;
        chk({tag, "_idle_ready"}, ready_o, 1'b0);
    endtask

    initial begin
        int ns, nr;
        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        annul_i  = 1'b0;
        ehold_i  = 1'b0;
        #1;
        chk("reset_stall", stall_o, 1'b0);
        chk("reset_ready", ready_o, 1'b0);
        chk("reset_result", result_o, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
        do_div("u_big_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 64'h0000000F_0FFFFFFF, 33);
        do_div("div0", 1'b1, 32'h0000_1234, 32'd0, 64'h00001234_FFFFFFFF, 1);

        // Annul at iteration 10 (cycle 11) leaves the previous result intact.
        issue(1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 11; i++) tick();
        #1;
        chk("annul_busy_stall", stall_o, 1'b1);
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("annul_stall_low", stall_o, 1'b0);
        chk("annul_ready_low", ready_o, 1'b0);
        tick();
        annul_i = 1'b0;
        nr = 0;
        ns = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ready_o) nr++;
            if (stall_o) ns++;
            tick();
        end
        chk("annul_no_ready", nr, 0);
        chk("annul_idle_stall", ns, 0);
        chk("annul_result_kept", result_o, 64'h00001234_FFFFFFFF);

        // annul_i together with start_i: nothing starts.
        issue(1'b0, 32'd50, 32'd5);
        annul_i = 1'b1;
        #1;
        chk("annul_start_stall", stall_o, 1'b0);
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        chk("annul_start_idle", stall_o, 1'b0);
        tick();
        start_i = 1'b1;
        #1;
        chk("annul_start_idle_accepts", stall_o, 1'b1);
        start_i = 1'b0;
        tick();
        #1;
        chk("annul_start_not_busy", stall_o, 1'b0);

        // ehold_i for 3 cycles in DONE with start_i held: ready for 4 cycles.
        issue(1'b0, 32'd100, 32'd7);
        run(ns, nr);
        chk("ehold_ready_cycle", nr, 33);
        nr = 0;
        ns = 0;
        for (int j = 0; j < 6; j++) begin
            ehold_i = (j < 3);
            if (j >= 4) start_i = 1'b0;
            #1;
            if (ready_o) nr++;
            if (stall_o) ns++;
            tick();
        end
        chk("ehold_ready_count", nr, 4);
        chk("ehold_no_restart_stall", ns, 0);
        do_div("after_ehold", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

        // Asynchronous reset in the middle of BUSY.
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        chk("rst_mid_stall", stall_o, 1'b0);
        chk("rst_mid_ready", ready_o, 1'b0);
        chk("rst_mid_result", result_o, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", ready_o, 1'b0);
        tick();
        do_div("after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_sequencer
